unidad_control_multiciclo: RTL
==============================

Name: unidad_control_multiciclo

Overview:
- Multicycle successor to the single-cycle control unit of the MIPS-subset datapath.
- A Moore FSM sequences every instruction through fetch, decode, execute, memory and writeback steps, driving per-cycle datapath controls.
- Adds two behaviours the single-cycle unit lacks: a memory-ready stall handshake and a sticky illegal-opcode trap.
- Opcode width, ALUOp width and opcode encodings are parameters.

Parameters:
- OPCODE_W, 6, opcode field width.
- ALUOP_W, 3, ALUOp bus width.
- OP_RTYPE, 6'b000000, R-type opcode.
- OP_LW, 6'b100011, load word.
- OP_SW, 6'b101011, store word.
- OP_BEQ, 6'b000100, branch if equal.
- OP_J, 6'b000010, jump.
- OP_ADDI, 6'b001000, add immediate.
- OP_MUL, 6'b011100, special R-format multiply; follows the R-type path with ALUOp=MUL.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous, active-low reset
- Opcode  in  OPCODE_W  instruction opcode; sampled only in DECODE
- mem_ready  in  1  memory completes the current access this cycle
- PCWrite  out  1  unconditional PC load
- PCWriteCond  out  1  PC load qualified by ALU zero
- IorD  out  1  memory address source: 0=PC, 1=ALUOut
- MemRead  out  1  memory read request
- MemToWrite  out  1  memory write request
- IRWrite  out  1  instruction register load
- MemToReg  out  1  writeback source: 0=ALUOut, 1=MDR
- RegDst  out  1  destination register: 0=rt, 1=rd
- RegisterWrite  out  1  register file write enable
- ALUSrcA  out  1  ALU A input: 0=PC, 1=rs
- ALUSrcB  out  2  ALU B input: 00=rt, 01=4, 10=sign-extended imm, 11=sign-extended imm<<2
- ALUOp  out  ALUOP_W  ALU function: 000=ADD, 001=SUB, 010=FUNCT, 011=MUL
- PCSource  out  2  next-PC source: 00=ALU, 01=ALUOut, 10=jump target
- instr_done  out  1  one-cycle pulse on the final cycle of each instruction
- illegal_op  out  1  sticky trap flag

Behaviour:
- rst_n=0 sampled at a clk edge → state IDLE, illegal_op=0. Reset is synchronous and active-low; it aborts any instruction mid-flight, including stalled memory states.
- IDLE: all outputs 0. Next state is FETCH unconditionally.
- All outputs are Moore-decoded from state, except mem_ready gating inside FETCH, MEM_RD and MEM_WR. Any output not listed for a state is 0.
- FETCH:
  - Asserts MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=ADD, PCSource=00.
  - IRWrite and PCWrite equal mem_ready.
  - Stays in FETCH while mem_ready=0; goes to DECODE when mem_ready=1.
- DECODE:
  - Asserts ALUSrcA=0, ALUSrcB=11, ALUOp=ADD.
  - Next state by Opcode: RTYPE/MUL→EXEC_R; LW/SW→MEM_ADDR; BEQ→BRANCH; J→JUMP; ADDI→EXEC_I; any other opcode→TRAP.
- EXEC_R: ALUSrcA=1, ALUSrcB=00, ALUOp=FUNCT (MUL if the decoded opcode was OP_MUL; latched in DECODE). Next state R_WB.
- R_WB: RegDst=1, RegisterWrite=1, MemToReg=0, instr_done=1. Next state FETCH.
- EXEC_I: ALUSrcA=1, ALUSrcB=10, ALUOp=ADD. Next state I_WB.
- I_WB: RegDst=0, RegisterWrite=1, MemToReg=0, instr_done=1. Next state FETCH.
- MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=ADD. Next state MEM_RD for LW, MEM_WR for SW.
- MEM_RD: MemRead=1, IorD=1. Waits while mem_ready=0, then goes to MEM_WB.
- MEM_WB: RegDst=0, MemToReg=1, RegisterWrite=1, instr_done=1. Next state FETCH.
- MEM_WR: MemToWrite=1, IorD=1. Waits while mem_ready=0. instr_done=mem_ready. Next state FETCH when mem_ready=1.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=SUB, PCWriteCond=1, PCSource=01, instr_done=1. Next state FETCH.
- JUMP: PCWrite=1, PCSource=10, instr_done=1. Next state FETCH.
- TRAP: all controls 0, illegal_op=1. Held until reset.
- Latency with mem_ready=1 throughout:
  - BEQ, J: 3 cycles.
  - R-type, MUL, ADDI, SW: 4 cycles.
  - LW: 5 cycles.
  - Each memory-state cycle with mem_ready=0 adds one cycle.
- MemRead and MemToWrite are never both 1 in the same cycle.
- Any unreachable state encoding recovers to IDLE on the next clock.

Decomposition:
- Package uc_pkg: state enum, ALUOp codes (ALU_ADD, ALU_SUB, ALU_FUNCT, ALU_MUL), ALUSrcB and PCSource encodings, default opcode constants.
- One sub-module, uc_decodificador_salidas: purely combinational state + mem_ready → control word. The top-level module keeps the state register, next-state logic and the sticky trap flag.

Test Plan:
- rst_n=0 for 2 cycles, then 1 → IDLE cycle with all outputs 0; next cycle FETCH with MemRead=1, IorD=0, IRWrite=1, PCWrite=1 (mem_ready=1).
- Opcode=000000, mem_ready=1 → FETCH, DECODE, EXEC_R (ALUOp=010), R_WB (RegDst=1, RegisterWrite=1, instr_done=1); back in FETCH on cycle 5.
- Opcode=100011, mem_ready held 0 for 3 cycles in MEM_RD → MEM_RD lasts 4 cycles with IorD=1; MEM_WB has MemToReg=1; total 8 cycles.
- Opcode=011100 → EXEC_R with ALUOp=011. Opcode=000100 → BRANCH with PCWriteCond=1, ALUOp=001, PCSource=01; 3 cycles total.
- Opcode=111111 → TRAP: illegal_op=1 and all controls 0 for 20 cycles. rst_n=0 one cycle → illegal_op=0 and IDLE.
- Opcode=101011 with rst_n=0 asserted during MEM_WR → next state IDLE, MemToWrite=0, no instr_done pulse.

Source files
------------

// File: rtl/uc_pkg.sv
// Shared encodings for the multicycle control unit: state codes, ALU/mux selects,
// default opcodes and the control word driven by the output decoder.
package uc_pkg;

    // Default MIPS-subset opcodes
    localparam logic [5:0] OP_RTYPE_DEF = 6'b000000;
    localparam logic [5:0] OP_LW_DEF    = 6'b100011;
    localparam logic [5:0] OP_SW_DEF    = 6'b101011;
    localparam logic [5:0] OP_BEQ_DEF   = 6'b000100;
    localparam logic [5:0] OP_J_DEF     = 6'b000010;
    localparam logic [5:0] OP_ADDI_DEF  = 6'b001000;
    localparam logic [5:0] OP_MUL_DEF   = 6'b011100;

    // FSM state codes; 14 and 15 are unreachable and fall back to IDLE
    typedef logic [3:0] estado_t;
    localparam estado_t S_IDLE     = 4'd0;
    localparam estado_t S_FETCH    = 4'd1;
    localparam estado_t S_DECODE   = 4'd2;
    localparam estado_t S_EXEC_R   = 4'd3;
    localparam estado_t S_R_WB     = 4'd4;
    localparam estado_t S_EXEC_I   = 4'd5;
    localparam estado_t S_I_WB     = 4'd6;
    localparam estado_t S_MEM_ADDR = 4'd7;
    localparam estado_t S_MEM_RD   = 4'd8;
    localparam estado_t S_MEM_WB   = 4'd9;
    localparam estado_t S_MEM_WR   = 4'd10;
    localparam estado_t S_BRANCH   = 4'd11;
    localparam estado_t S_JUMP     = 4'd12;
    localparam estado_t S_TRAP     = 4'd13;

    // ALU function codes
    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_FUNCT = 3'b010;
    localparam logic [2:0] ALU_MUL   = 3'b011;

    // ALU B-input mux selects
    localparam logic [1:0] SRCB_RT     = 2'b00;
    localparam logic [1:0] SRCB_CUATRO = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    // Next-PC mux selects
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // One cycle's worth of datapath controls
    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic [1:0] pc_source;
        logic       instr_done;
    } ctrl_t;

endpackage

// File: rtl/uc_decodificador_salidas.sv
// Combinational output decoder: state plus mem_ready gating -> control word.
// IDLE, TRAP and any unreachable code drive an all-zero word.
module uc_decodificador_salidas
    import uc_pkg::*;
(
    input  estado_t estado,
    input  logic    mem_ready,
    input  logic    es_mul,
    output ctrl_t   ctrl
);

    // Moore decode; only the memory states look at mem_ready
    always_comb begin
        ctrl = '0;
        case (estado)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.iord      = 1'b0;
                ctrl.alu_src_a = 1'b0;
                ctrl.alu_src_b = SRCB_CUATRO;
                ctrl.alu_op    = ALU_ADD;
                ctrl.pc_source = PCSRC_ALU;
                ctrl.ir_write  = mem_ready;
                ctrl.pc_write  = mem_ready;
            end
            S_DECODE: begin
                ctrl.alu_src_a = 1'b0;
                ctrl.alu_src_b = SRCB_IMM_SH;
                ctrl.alu_op    = ALU_ADD;
            end
            S_EXEC_R: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_RT;
                ctrl.alu_op    = es_mul ? ALU_MUL : ALU_FUNCT;
            end
            S_R_WB: begin
                ctrl.reg_dst    = 1'b1;
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_EXEC_I, S_MEM_ADDR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALU_ADD;
            end
            S_I_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_MEM_RD: begin
                ctrl.mem_read = 1'b1;
                ctrl.iord     = 1'b1;
            end
            S_MEM_WB: begin
                ctrl.mem_to_reg = 1'b1;
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_MEM_WR: begin
                ctrl.mem_write  = 1'b1;
                ctrl.iord       = 1'b1;
                ctrl.instr_done = mem_ready;
            end
            S_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = SRCB_RT;
                ctrl.alu_op        = ALU_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PCSRC_ALUOUT;
                ctrl.instr_done    = 1'b1;
            end
            S_JUMP: begin
                ctrl.pc_write   = 1'b1;
                ctrl.pc_source  = PCSRC_JUMP;
                ctrl.instr_done = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/unidad_control_multiciclo.sv
// Multicycle MIPS-subset control unit: state register, next-state logic,
// opcode flags captured in DECODE and the sticky illegal-opcode trap.
module unidad_control_multiciclo
    import uc_pkg::*;
#(
    parameter int                    OPCODE_W = 6,
    parameter int                    ALUOP_W  = 3,
    parameter logic [OPCODE_W-1:0]   OP_RTYPE = OP_RTYPE_DEF,
    parameter logic [OPCODE_W-1:0]   OP_LW    = OP_LW_DEF,
    parameter logic [OPCODE_W-1:0]   OP_SW    = OP_SW_DEF,
    parameter logic [OPCODE_W-1:0]   OP_BEQ   = OP_BEQ_DEF,
    parameter logic [OPCODE_W-1:0]   OP_J     = OP_J_DEF,
    parameter logic [OPCODE_W-1:0]   OP_ADDI  = OP_ADDI_DEF,
    parameter logic [OPCODE_W-1:0]   OP_MUL   = OP_MUL_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [OPCODE_W-1:0] Opcode,
    input  logic                mem_ready,
    output logic                PCWrite,
    output logic                PCWriteCond,
    output logic                IorD,
    output logic                MemRead,
    output logic                MemToWrite,
    output logic                IRWrite,
    output logic                MemToReg,
    output logic                RegDst,
    output logic                RegisterWrite,
    output logic                ALUSrcA,
    output logic [1:0]          ALUSrcB,
    output logic [ALUOP_W-1:0]  ALUOp,
    output logic [1:0]          PCSource,
    output logic                instr_done,
    output logic                illegal_op
);

    estado_t estado, estado_sig;
    logic    es_mul;   // opcode seen in DECODE was MUL
    logic    es_lw;    // opcode seen in DECODE was LW (else SW on the memory path)
    ctrl_t   ctrl;

    // Next-state: memory states hold until mem_ready, TRAP holds until reset
    always_comb begin
        estado_sig = S_IDLE;
        case (estado)
            S_IDLE:     estado_sig = S_FETCH;
            S_FETCH:    estado_sig = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                if (Opcode == OP_RTYPE || Opcode == OP_MUL) estado_sig = S_EXEC_R;
                else if (Opcode == OP_LW || Opcode == OP_SW) estado_sig = S_MEM_ADDR;
                else if (Opcode == OP_BEQ)  estado_sig = S_BRANCH;
                else if (Opcode == OP_J)    estado_sig = S_JUMP;
                else if (Opcode == OP_ADDI) estado_sig = S_EXEC_I;
                else                        estado_sig = S_TRAP;
            end
            S_EXEC_R:   estado_sig = S_R_WB;
            S_R_WB:     estado_sig = S_FETCH;
            S_EXEC_I:   estado_sig = S_I_WB;
            S_I_WB:     estado_sig = S_FETCH;
            S_MEM_ADDR: estado_sig = es_lw ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:   estado_sig = mem_ready ? S_MEM_WB : S_MEM_RD;
            S_MEM_WB:   estado_sig = S_FETCH;
            S_MEM_WR:   estado_sig = mem_ready ? S_FETCH : S_MEM_WR;
            S_BRANCH:   estado_sig = S_FETCH;
            S_JUMP:     estado_sig = S_FETCH;
            S_TRAP:     estado_sig = S_TRAP;
            default:    estado_sig = S_IDLE;
        endcase
    end

    // State register, DECODE-time opcode flags and sticky trap flag
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            estado     <= S_IDLE;
            es_mul     <= 1'b0;
            es_lw      <= 1'b0;
            illegal_op <= 1'b0;
        end else begin
            estado <= estado_sig;
            if (estado == S_DECODE) begin
                es_mul <= (Opcode == OP_MUL);
                es_lw  <= (Opcode == OP_LW);
            end
            if (estado_sig == S_TRAP)
                illegal_op <= 1'b1;
        end
    end

    uc_decodificador_salidas u_dec (
        .estado    (estado),
        .mem_ready (mem_ready),
        .es_mul    (es_mul),
        .ctrl      (ctrl)
    );

    assign PCWrite       = ctrl.pc_write;
    assign PCWriteCond   = ctrl.pc_write_cond;
    assign IorD          = ctrl.iord;
    assign MemRead       = ctrl.mem_read;
    assign MemToWrite    = ctrl.mem_write;
    assign IRWrite       = ctrl.ir_write;
    assign MemToReg      = ctrl.mem_to_reg;
    assign RegDst        = ctrl.reg_dst;
    assign RegisterWrite = ctrl.reg_write;
    assign ALUSrcA       = ctrl.alu_src_a;
    assign ALUSrcB       = ctrl.alu_src_b;
    assign ALUOp         = ALUOP_W'(ctrl.alu_op);
    assign PCSource      = ctrl.pc_source;
    assign instr_done    = ctrl.instr_done;

endmodule
